// File: rtl/pi_loop_sequencer.sv
// pi_loop_sequencer: shares one PI core across the speed, iq and id loops once per PWM tick
module pi_loop_sequencer #(
  parameter int N = 10,
  parameter int F = 9,
  parameter int SPEED_DIV = 8,
  parameter int TIMEOUT = 64,
  parameter logic signed [N-1:0] KP_SPD = 'sd64,
  parameter logic signed [N-1:0] KI_SPD = 'sd8,
  parameter logic signed [N-1:0] KAW_SPD = 'sd16,
  parameter logic signed [N-1:0] KP_IQ = 'sd64,
  parameter logic signed [N-1:0] KI_IQ = 'sd8,
  parameter logic signed [N-1:0] KAW_IQ = 'sd16,
  parameter logic signed [N-1:0] KP_ID = 'sd64,
  parameter logic signed [N-1:0] KI_ID = 'sd8,
  parameter logic signed [N-1:0] KAW_ID = 'sd16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         clr_fault,
  input  logic [N-1:0] speed_ref,
  input  logic [N-1:0] speed,
  input  logic [N-1:0] id_ref,
  input  logic [N-1:0] id,
  input  logic [N-1:0] iq,
  output logic         pi_req,
  output logic [1:0]   pi_ch,
  output logic [N-1:0] pi_ref,
  output logic [N-1:0] pi_fb,
  output logic [N-1:0] pi_kp,
  output logic [N-1:0] pi_ki,
  output logic [N-1:0] pi_kaw,
  input  logic         pi_ack,
  input  logic [N-1:0] pi_out,
  output logic [N-1:0] torque_ref,
  output logic [N-1:0] vq,
  output logic [N-1:0] vd,
  output logic         busy,
  output logic         done,
  output logic         overrun,
  output logic         fault
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = SPEED_DIV > 1 ? $clog2(SPEED_DIV) : 1;
  localparam logic [2:0] S_IDLE = 3'd0, S_SPD = 3'd1, S_IQ = 3'd2, S_ID = 3'd3, S_FIN = 3'd4;

  if (F >= N || SPEED_DIV < 1 || TIMEOUT < 2) begin : g_bad_param
    $error("pi_loop_sequencer: invalid parameters");
  end

  logic [2:0]    state_q, state_d;
  logic          gap_q, gap_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [SW-1:0] spd_cnt_q, spd_cnt_d;
  logic [N-1:0]  sr_q, sr_d, sp_q, sp_d, idr_q, idr_d, id_q, id_d, iq_q, iq_d;
  logic [N-1:0]  torque_q, torque_d, vq_q, vq_d, vd_q, vd_d;
  logic          fault_q, fault_d, overrun_q, overrun_d;
  logic          is_spd, is_iq, is_id, req;

  assign is_spd = state_q == S_SPD;
  assign is_iq  = state_q == S_IQ;
  assign is_id  = state_q == S_ID;
  // gap_q marks the idle cycle between channels (and before done)
  assign req    = (is_spd || is_iq || is_id) && !gap_q;

  always_comb begin
    state_d   = state_q;
    gap_d     = 1'b0;
    tmo_d     = (req && !pi_ack) ? tmo_q + 1'b1 : '0;
    spd_cnt_d = spd_cnt_q;
    sr_d      = sr_q;
    sp_d      = sp_q;
    idr_d     = idr_q;
    id_d      = id_q;
    iq_d      = iq_q;
    torque_d  = torque_q;
    vq_d      = vq_q;
    vd_d      = vd_q;
    fault_d   = clr_fault ? 1'b0 : fault_q;
    overrun_d = clr_fault ? 1'b0 : (overrun_q || (tick && state_q != S_IDLE));
    case (state_q)
      S_IDLE: if (tick && !fault_q && !clr_fault) begin
        sr_d      = speed_ref;
        sp_d      = speed;
        idr_d     = id_ref;
        id_d      = id;
        iq_d      = iq;
        state_d   = spd_cnt_q == '0 ? S_SPD : S_IQ;
        spd_cnt_d = spd_cnt_q == SW'(SPEED_DIV - 1) ? '0 : spd_cnt_q + 1'b1;
      end
      S_SPD, S_IQ, S_ID: if (req && pi_ack) begin
        state_d  = is_spd ? S_IQ : is_iq ? S_ID : S_FIN;
        gap_d    = 1'b1;
        torque_d = is_spd ? pi_out : torque_q;
        vq_d     = is_iq ? pi_out : vq_q;
        vd_d     = is_id ? pi_out : vd_q;
      end else if (req && tmo_q == TW'(TIMEOUT - 1)) begin
        fault_d = 1'b1;
        vq_d    = '0;
        vd_d    = '0;
        state_d = S_IDLE;
      end
      S_FIN: state_d = gap_q ? S_FIN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= S_IDLE;
      gap_q     <= 1'b0;
      tmo_q     <= '0;
      spd_cnt_q <= '0;
      sr_q      <= '0;
      sp_q      <= '0;
      idr_q     <= '0;
      id_q      <= '0;
      iq_q      <= '0;
      torque_q  <= '0;
      vq_q      <= '0;
      vd_q      <= '0;
      fault_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      tmo_q     <= tmo_d;
      spd_cnt_q <= spd_cnt_d;
      sr_q      <= sr_d;
      sp_q      <= sp_d;
      idr_q     <= idr_d;
      id_q      <= id_d;
      iq_q      <= iq_d;
      torque_q  <= torque_d;
      vq_q      <= vq_d;
      vd_q      <= vd_d;
      fault_q   <= fault_d;
      overrun_q <= overrun_d;
    end

  assign pi_req     = req;
  assign pi_ch      = is_iq ? 2'd1 : is_id ? 2'd2 : 2'd0;
  assign pi_ref     = is_spd ? sr_q : is_iq ? torque_q : is_id ? idr_q : '0;
  assign pi_fb      = is_spd ? sp_q : is_iq ? iq_q : is_id ? id_q : '0;
  assign pi_kp      = is_spd ? KP_SPD : is_iq ? KP_IQ : is_id ? KP_ID : '0;
  assign pi_ki      = is_spd ? KI_SPD : is_iq ? KI_IQ : is_id ? KI_ID : '0;
  assign pi_kaw     = is_spd ? KAW_SPD : is_iq ? KAW_IQ : is_id ? KAW_ID : '0;
  assign torque_ref = torque_q;
  assign vq         = vq_q;
  assign vd         = vd_q;
  assign busy       = state_q != S_IDLE;
  assign done       = state_q == S_FIN && !gap_q;
  assign overrun    = overrun_q;
  assign fault      = fault_q;
endmodule

// File: tb/tb_pi_loop_sequencer.sv
// tb_pi_loop_sequencer: randomized PI-core responder with a per-control-cycle reference model
module tb_pi_loop_sequencer;
  localparam int N = 10;
  logic clk = 0, rst = 1, tick = 0, clr_fault = 0;
  logic [N-1:0] speed_ref = 0, speed = 0, id_ref = 0, id = 0, iq = 0;
  logic pi_req, pi_ack = 0, busy, done, overrun, fault;
  logic [1:0] pi_ch;
  logic [N-1:0] pi_ref, pi_fb, pi_kp, pi_ki, pi_kaw, pi_out = 0, torque_ref, vq, vd;

  pi_loop_sequencer #(.N(N), .F(9), .SPEED_DIV(8), .TIMEOUT(64),
    .KP_SPD(10'sd64), .KI_SPD(10'sd8), .KAW_SPD(10'sd16),
    .KP_IQ(10'sd48), .KI_IQ(10'sd6), .KAW_IQ(10'sd12),
    .KP_ID(10'sd32), .KI_ID(10'sd4), .KAW_ID(10'sd10)) dut (
    .clk(clk), .rst(rst), .tick(tick), .clr_fault(clr_fault),
    .speed_ref(speed_ref), .speed(speed), .id_ref(id_ref), .id(id), .iq(iq),
    .pi_req(pi_req), .pi_ch(pi_ch), .pi_ref(pi_ref), .pi_fb(pi_fb),
    .pi_kp(pi_kp), .pi_ki(pi_ki), .pi_kaw(pi_kaw), .pi_ack(pi_ack), .pi_out(pi_out),
    .torque_ref(torque_ref), .vq(vq), .vd(vd), .busy(busy), .done(done),
    .overrun(overrun), .fault(fault));

  always #5 clk = ~clk;

  int n_run = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int kp_t[3] = '{64, 48, 32};
  int ki_t[3] = '{8, 6, 4};
  int kaw_t[3] = '{16, 12, 10};

  int dly = 0, wcnt = 0, done_cnt = 0;
  bit hang = 0, fixed = 0, spur = 0;
  int q_ch[$], q_ref[$], q_fb[$], q_kp[$], q_ki[$], q_kaw[$], q_out[$];

  initial forever begin
    @(negedge clk);
    pi_ack = 0;
    if (done) done_cnt++;
    if (pi_req && !hang) begin
      if (wcnt == dly) begin
        pi_ack = 1;
        pi_out = fixed ? (pi_ch == 0 ? 10'd256 : pi_ch == 1 ? 10'd100 : N'($urandom)) : N'($urandom);
        q_ch.push_back(int'(pi_ch));
        q_ref.push_back(int'(pi_ref));
        q_fb.push_back(int'(pi_fb));
        q_kp.push_back(int'(pi_kp));
        q_ki.push_back(int'(pi_ki));
        q_kaw.push_back(int'(pi_kaw));
        q_out.push_back(int'(pi_out));
        wcnt = 0;
      end else wcnt++;
    end else begin
      wcnt = 0;
      if (spur && !pi_req && $urandom_range(0, 1) == 1) begin
        pi_ack = 1;
        pi_out = N'($urandom);
      end
    end
  end

  int k = 0;
  logic [N-1:0] exp_torque = 0, exp_vq = 0, exp_vd = 0;

  task automatic rand_inputs();
    speed_ref = N'($urandom);
    speed = N'($urandom);
    id_ref = N'($urandom);
    id = N'($urandom);
    iq = N'($urandom);
  endtask

  task automatic run_cycle(input int d, input bit ovr);
    logic [N-1:0] s_sr, s_sp, s_ir, s_id, s_iq;
    int exp_ch[$];
    int lat, dc0, ch, r, f, nch;
    bit got, ov;
    dly = d;
    q_ch.delete(); q_ref.delete(); q_fb.delete(); q_kp.delete();
    q_ki.delete(); q_kaw.delete(); q_out.delete();
    rand_inputs();
    s_sr = speed_ref; s_sp = speed; s_ir = id_ref; s_id = id; s_iq = iq;
    if (k % 8 == 0) exp_ch.push_back(0);
    exp_ch.push_back(1);
    exp_ch.push_back(2);
    nch = exp_ch.size();
    dc0 = done_cnt; got = 0; ov = 0; lat = 0;
    @(negedge clk);
    tick = 1;
    for (int c = 1; c <= 400 && !got; c++) begin
      @(negedge clk);
      tick = 0;
      if (c == 1) rand_inputs();
      if (ovr && !ov && pi_req && pi_ch == 1) begin
        tick = 1;
        ov = 1;
      end
      if (done) begin
        got = 1;
        lat = c;
      end
    end
    tick = 0;
    check("done_seen", got, 1);
    check("latency", lat, nch * (d + 1) + nch + 1);
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt - dc0, 1);
    check("num_requests", q_ch.size(), nch);
    for (int j = 0; j < nch && j < q_ch.size(); j++) begin
      ch = exp_ch[j];
      r = ch == 0 ? int'(s_sr) : ch == 1 ? int'(exp_torque) : int'(s_ir);
      f = ch == 0 ? int'(s_sp) : ch == 1 ? int'(s_iq) : int'(s_id);
      check("pi_ch", q_ch[j], ch);
      check("pi_ref", q_ref[j], r);
      check("pi_fb", q_fb[j], f);
      check("pi_kp", q_kp[j], kp_t[ch]);
      check("pi_ki", q_ki[j], ki_t[ch]);
      check("pi_kaw", q_kaw[j], kaw_t[ch]);
      if (ch == 0) exp_torque = N'(q_out[j]);
      if (ch == 1) exp_vq = N'(q_out[j]);
      if (ch == 2) exp_vd = N'(q_out[j]);
    end
    check("torque_ref", torque_ref, exp_torque);
    check("vq", vq, exp_vq);
    check("vd", vd, exp_vd);
    check("overrun", overrun, ovr);
    check("busy_after", busy, 0);
    check("fault_after", fault, 0);
    k++;
  endtask

  int spd_runs, dc, reqs;
  bit seen, fseen;

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rst_pi_req", pi_req, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_torque", torque_ref, 0);
    check("rst_vq", vq, 0);
    check("rst_vd", vd, 0);
    check("rst_fault", fault, 0);
    check("rst_overrun", overrun, 0);

    fixed = 1;
    run_cycle(0, 0);
    fixed = 0;
    check("torque_256", torque_ref, 256);
    check("vq_100", vq, 100);

    spur = 1;
    spd_runs = 0;
    dc = done_cnt;
    for (int t = 0; t < 16; t++) begin
      run_cycle(2, 0);
      foreach (q_ch[j]) if (q_ch[j] == 0) spd_runs++;
    end
    spur = 0;
    check("speed_runs_16", spd_runs, 2);
    check("done_count_16", done_cnt - dc, 16);

    dly = 20;
    rand_inputs();
    @(negedge clk);
    tick = 1;
    seen = 0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      tick = 0;
      if (pi_req && pi_ch == 2) seen = 1;
    end
    check("reached_id", seen, 1);
    #1 rst = 1;
    #2 rst = 0;
    @(negedge clk);
    check("mid_rst_pi_req", pi_req, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_torque", torque_ref, 0);
    check("mid_rst_vq", vq, 0);
    check("mid_rst_vd", vd, 0);
    k = 0; exp_torque = 0; exp_vq = 0; exp_vd = 0;
    run_cycle(1, 0);

    run_cycle(3, 1);
    @(negedge clk);
    clr_fault = 1;
    tick = 1;
    @(negedge clk);
    clr_fault = 0;
    tick = 0;
    check("clr_overrun", overrun, 0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (pi_req || busy) seen = 1;
    end
    check("clr_tick_ignored", seen, 0);
    run_cycle(0, 0);

    hang = 1;
    @(negedge clk);
    tick = 1;
    reqs = 0;
    fseen = 0;
    for (int c = 0; c < 200 && !fseen; c++) begin
      @(negedge clk);
      tick = 0;
      if (fault) fseen = 1;
      else if (pi_req) reqs++;
    end
    k++;
    exp_vq = 0; exp_vd = 0;
    check("fault_set", fseen, 1);
    check("timeout_cycles", reqs, 64);
    check("fault_vq", vq, 0);
    check("fault_vd", vd, 0);
    check("fault_torque", torque_ref, exp_torque);
    check("fault_busy", busy, 0);
    @(negedge clk);
    tick = 1;
    @(negedge clk);
    tick = 0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (pi_req || busy) seen = 1;
    end
    check("fault_tick_ignored", seen, 0);
    check("fault_sticky", fault, 1);
    check("fault_no_overrun", overrun, 0);
    hang = 0;
    clr_fault = 1;
    @(negedge clk);
    clr_fault = 0;
    check("fault_cleared", fault, 0);
    run_cycle(1, 0);
    run_cycle(0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
